// File: rtl/mcu_spi_slave_pkg.sv
// rtl/mcu_spi_slave_pkg.sv - shared types and constants for the MCU SPI responder
package mcu_spi_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA
  } spi_slv_state_t;

  // Command byte layout: {wr, addr[6:0]}
  localparam int SPI_CMD_WR_BIT = 7;

endpackage

// File: rtl/mcu_spi_slave_sync_edge_det.sv
// rtl/mcu_spi_slave_sync_edge_det.sv - synchroniser with rise/fall pulse outputs
module sync_edge_det #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic [STAGES:0]   r_warm;
  logic              w_q;

  assign w_q = r_sync[STAGES-1];

  // Synchroniser chain plus one history flop. r_warm masks edges until the
  // chain and history hold real samples, so a line that was already at its
  // non-preset level during reset never produces a phantom edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
      r_warm <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= w_q;
      r_warm <= {r_warm[STAGES-1:0], 1'b1};
    end
  end

  assign o_rise = r_warm[STAGES] & w_q & ~r_prev;
  assign o_fall = r_warm[STAGES] & ~w_q & r_prev;

endmodule

// File: rtl/mcu_spi_slave.sv
// rtl/mcu_spi_slave.sv - SPI mode-0 responder giving an MCU access to a 7-bit register space
module mcu_spi_slave
  import mcu_spi_slave_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int AUTO_INC    = 1
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       frame_active
);

  spi_slv_state_t r_state;
  spi_slv_state_t w_state_nxt;

  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic       w_mosi_q;
  logic       w_sck_rise;
  logic       w_sck_fall;
  logic       w_cs_rise;
  logic       w_cs_fall;
  logic       w_in_frame;
  logic       w_rise_act;
  logic       w_fall_act;
  logic       w_byte_done;
  logic [7:0] w_byte;

  logic [2:0] r_bit_cnt;
  logic [6:0] r_rx;
  logic [6:0] r_tx;
  logic       r_miso;
  logic       r_oe;
  logic [6:0] r_addr;
  logic [7:0] r_wdata;
  logic       r_wr;
  logic       r_rd;
  logic       r_rd_d1;
  logic       r_rd_d2;
  logic       r_wr_flag;

  sync_edge_det #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sck_sync (
    .i_clk  (clk28),
    .i_rst  (rst),
    .i_d    (spi_sck),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  sync_edge_det #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_cs_sync (
    .i_clk  (clk28),
    .i_rst  (rst),
    .i_d    (spi_cs_n),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  // MOSI gets the same depth as SCK so the sampled bit lines up with the detected rise
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_mosi_sync <= {SYNC_STAGES{1'b1}};
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  assign w_mosi_q    = r_mosi_sync[SYNC_STAGES-1];
  // Outside a frame the chip is deselected, so SCK activity is ignored
  assign w_in_frame  = (r_state != ST_IDLE);
  assign w_rise_act  = w_in_frame & w_sck_rise;
  assign w_fall_act  = w_in_frame & w_sck_fall;
  assign w_byte      = {r_rx, w_mosi_q};
  assign w_byte_done = w_rise_act & (r_bit_cnt == 3'd7);

  // FSM state register
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: CS edges frame the transfer, first full byte is the command
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_cs_fall) w_state_nxt = ST_CMD;
      ST_CMD: begin
        if (w_cs_rise)        w_state_nxt = ST_IDLE;
        else if (w_byte_done) w_state_nxt = ST_DATA;
      end
      ST_DATA: if (w_cs_rise) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    frame_active = (r_state != ST_IDLE);
  end

  // Shift registers, bit counter, address counter and register strobes
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= 3'd0;
      r_rx      <= 7'd0;
      r_tx      <= 7'h7F;
      r_miso    <= 1'b1;
      r_oe      <= 1'b0;
      r_addr    <= 7'd0;
      r_wdata   <= 8'd0;
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
      r_rd_d1   <= 1'b0;
      r_rd_d2   <= 1'b0;
      r_wr_flag <= 1'b0;
    end else begin
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_rd_d1 <= r_rd;
      r_rd_d2 <= r_rd_d1;

      // Post-increment lands the clock after the write strobe
      if (r_wr && (AUTO_INC != 0)) begin
        r_addr <= r_addr + 7'd1;
      end

      if (w_cs_fall && (r_state == ST_IDLE)) begin
        r_bit_cnt <= 3'd0;
        r_oe      <= 1'b1;
        r_miso    <= 1'b1;
        r_tx      <= 7'h7F;
      end else if (w_cs_rise) begin
        // Partial byte is simply forgotten; nothing is strobed
        r_bit_cnt <= 3'd0;
        r_oe      <= 1'b0;
        r_miso    <= 1'b1;
        r_tx      <= 7'h7F;
      end else if (w_in_frame) begin
        if (w_rise_act) begin
          r_rx      <= w_byte[6:0];
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            if (r_state == ST_CMD) begin
              r_wr_flag <= w_byte[SPI_CMD_WR_BIT];
              r_addr    <= w_byte[6:0];
              r_rd      <= ~w_byte[SPI_CMD_WR_BIT];
            end else if (r_wr_flag) begin
              r_wdata <= w_byte;
              r_wr    <= 1'b1;
            end else begin
              // Read burst: step to the next address and prefetch it
              if (AUTO_INC != 0) begin
                r_addr <= r_addr + 7'd1;
              end
              r_rd <= 1'b1;
            end
          end
        end else if (w_fall_act && (r_bit_cnt != 3'd0)) begin
          // The fall right after a byte boundary keeps the freshly loaded MSB
          r_miso <= r_tx[6];
          r_tx   <= {r_tx[5:0], 1'b1};
        end

        // Read data returns two clocks after the request
        if (r_rd_d2) begin
          r_miso <= reg_rdata[7];
          r_tx   <= reg_rdata[6:0];
        end
      end
    end
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = r_oe;
  assign reg_addr    = r_addr;
  assign reg_wdata   = r_wdata;
  assign reg_wr      = r_wr;
  assign reg_rd      = r_rd;

endmodule
